// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer
//
// Multi-phase timing controller. When Start is accepted, a duration is
// captured for every phase. The remaining count of the current phase is
// counted down to zero, and the counter is then reloaded with the next
// phase's duration. A one-cycle PhaseTick marks every phase boundary, and
// Done marks the expiry of the last phase.
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous active-high reset, overrides everything
//   Start      in   begin a sequence (sampled only while idle)
//   Pause      in   freeze the countdown (honoured only while running)
//   Dur        in   packed per-phase durations, phase i = Dur[CNT_W*i +: CNT_W]
//   Phase      out  index of the current phase
//   Q          out  remaining count of the current phase
//   S          out  OR-reduction of Q (combinational)
//   Busy       out  high while a sequence is running
//   PhaseTick  out  one-cycle pulse on each phase boundary
//   Done       out  one-cycle pulse when the last phase expires
// ----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int N_PHASES = 4,
  parameter int CNT_W    = 4,
  parameter int PH_W     = 2
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Pause,
  input  logic [N_PHASES*CNT_W-1:0] Dur,
  output logic [PH_W-1:0]           Phase,
  output logic [CNT_W-1:0]          Q,
  output logic                      S,
  output logic                      Busy,
  output logic                      PhaseTick,
  output logic                      Done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  logic [PH_W-1:0]    phase_reg;
  logic [CNT_W-1:0]   q_reg;
  logic               busy_reg;
  logic               tick_reg;
  logic               done_reg;
  logic [CNT_W-1:0]   snap_reg [N_PHASES];

  // Unpacked view of the duration bus.
  logic [CNT_W-1:0]   dur_arr [N_PHASES];

  genvar gi;
  generate
    for (gi = 0; gi < N_PHASES; gi++) begin : g_dur
      assign dur_arr[gi] = Dur[CNT_W*gi +: CNT_W];
    end
  endgenerate

  logic [PH_W-1:0] phase_next;
  logic            last_phase;

  // phase_next is used only when last_phase is low, so it never leaves
  // the valid index range.
  assign phase_next = phase_reg + PH_W'(1);
  assign last_phase = (phase_reg == PH_W'(N_PHASES - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      q_reg     <= '0;
      busy_reg  <= 1'b0;
      tick_reg  <= 1'b0;
      done_reg  <= 1'b0;
      for (int i = 0; i < N_PHASES; i++) begin
        snap_reg[i] <= '0;
      end
    end else begin
      // Both strobes are single-cycle pulses unless re-asserted below.
      tick_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            for (int i = 0; i < N_PHASES; i++) begin
              snap_reg[i] <= dur_arr[i];
            end
            // The live bus is used for phase 0 because the snapshot is
            // being written in this same cycle.
            q_reg     <= dur_arr[0];
            phase_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Pause freezes everything, including a pending boundary at Q=0.
          if (!Pause) begin
            if (q_reg != '0) begin
              q_reg <= q_reg - CNT_W'(1);
            end else if (!last_phase) begin
              phase_reg <= phase_next;
              q_reg     <= snap_reg[phase_next];
              tick_reg  <= 1'b1;
            end else begin
              // Q stays 0 and Phase stays at the last index until restart.
              tick_reg  <= 1'b1;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Phase     = phase_reg;
  assign Q         = q_reg;
  assign S         = |q_reg;
  assign Busy      = busy_reg;
  assign PhaseTick = tick_reg;
  assign Done      = done_reg;

endmodule
